// File: rtl/mirfak_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mirfak_bus_arbiter
// Purpose  : Two-master / one-slave Wishbone classic arbiter. The instruction
//            fetch port (iport) and the load/store port (dport) share one
//            memory port. A grant is held for a whole transaction. dport has
//            priority, and a burst counter stops iport from being starved.
// Ports    : clk_i, rstn_i                 clock, async active-low reset
//            iport_*_i / dport_*_i         master request side (addr, dat_w,
//                                          sel, we, cyc, stb)
//            iport_*_o / dport_*_o         master response side (dat_r, ack,
//                                          err)
//            bus_*_o                       slave request side
//            bus_dat_r_i, bus_ack_i,
//            bus_err_i                     slave response side
// Revision : 1.0 - initial release
// ============================================================================
module mirfak_bus_arbiter #(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic [31:0] iport_addr_i,
    input  logic [31:0] iport_dat_w_i,
    input  logic [3:0]  iport_sel_i,
    input  logic        iport_we_i,
    input  logic        iport_cyc_i,
    input  logic        iport_stb_i,
    output logic [31:0] iport_dat_r_o,
    output logic        iport_ack_o,
    output logic        iport_err_o,

    input  logic [31:0] dport_addr_i,
    input  logic [31:0] dport_dat_w_i,
    input  logic [3:0]  dport_sel_i,
    input  logic        dport_we_i,
    input  logic        dport_cyc_i,
    input  logic        dport_stb_i,
    output logic [31:0] dport_dat_r_o,
    output logic        dport_ack_o,
    output logic        dport_err_o,

    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_dat_w_o,
    output logic [3:0]  bus_sel_o,
    output logic        bus_we_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    input  logic [31:0] bus_dat_r_i,
    input  logic        bus_ack_i,
    input  logic        bus_err_i
);

    localparam int DCNT_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [DCNT_W-1:0] c_max_burst = DCNT_W'(MAX_DATA_BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DCNT_W-1:0] r_dcnt;
    logic [DCNT_W-1:0] w_dcnt_nxt;
    logic [DCNT_W-1:0] w_dcnt_inc;
    logic              w_req_i;
    logic              w_req_d;

    assign w_req_i = iport_cyc_i & iport_stb_i;
    assign w_req_d = dport_cyc_i & dport_stb_i;

    // Saturating increment of the consecutive-dport-grant counter.
    assign w_dcnt_inc = (r_dcnt == c_max_burst) ? r_dcnt : r_dcnt + DCNT_W'(1);

    // Read data goes to both masters; each one qualifies it with its own ack.
    assign iport_dat_r_o = bus_dat_r_i;
    assign dport_dat_r_o = bus_dat_r_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        bus_addr_o  = 32'h0;
        bus_dat_w_o = 32'h0;
        bus_sel_o   = 4'h0;
        bus_we_o    = 1'b0;
        bus_cyc_o   = 1'b0;
        bus_stb_o   = 1'b0;
        iport_ack_o = 1'b0;
        iport_err_o = 1'b0;
        dport_ack_o = 1'b0;
        dport_err_o = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // dport wins unless iport is waiting and dport already used
                // its full burst allowance.
                if (w_req_d && (!w_req_i || (r_dcnt < c_max_burst))) begin
                    w_state_nxt = ST_GNT_D;
                    w_dcnt_nxt  = w_req_i ? w_dcnt_inc : '0;
                end else if (w_req_i) begin
                    w_state_nxt = ST_GNT_I;
                    w_dcnt_nxt  = '0;
                end
            end

            ST_GNT_I: begin
                bus_addr_o  = iport_addr_i;
                bus_dat_w_o = iport_dat_w_i;
                bus_sel_o   = iport_sel_i;
                bus_we_o    = iport_we_i;
                bus_cyc_o   = iport_cyc_i;
                bus_stb_o   = iport_stb_i & iport_cyc_i;
                // A master that dropped cyc has abandoned the cycle; a late
                // slave response must not reach it.
                iport_ack_o = bus_ack_i & iport_cyc_i;
                iport_err_o = bus_err_i & iport_cyc_i;
                if (!iport_cyc_i || bus_ack_i || bus_err_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_GNT_D: begin
                bus_addr_o  = dport_addr_i;
                bus_dat_w_o = dport_dat_w_i;
                bus_sel_o   = dport_sel_i;
                bus_we_o    = dport_we_i;
                bus_cyc_o   = dport_cyc_i;
                bus_stb_o   = dport_stb_i & dport_cyc_i;
                dport_ack_o = bus_ack_i & dport_cyc_i;
                dport_err_o = bus_err_i & dport_cyc_i;
                if (!dport_cyc_i || bus_ack_i || bus_err_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mirfak_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mirfak_bus_arbiter
// Purpose  : Directed self-checking bench for mirfak_bus_arbiter
//            (MAX_DATA_BURST = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mirfak_bus_arbiter;

    logic        clk;
    logic        rstn;
    logic [31:0] iport_addr, iport_dat_w, iport_dat_r;
    logic [3:0]  iport_sel;
    logic        iport_we, iport_cyc, iport_stb, iport_ack, iport_err;
    logic [31:0] dport_addr, dport_dat_w, dport_dat_r;
    logic [3:0]  dport_sel;
    logic        dport_we, dport_cyc, dport_stb, dport_ack, dport_err;
    logic [31:0] bus_addr, bus_dat_w, bus_dat_r;
    logic [3:0]  bus_sel;
    logic        bus_we, bus_cyc, bus_stb, bus_ack, bus_err;

    int n_checks = 0;
    int n_errors = 0;

    mirfak_bus_arbiter #(.MAX_DATA_BURST(4)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .iport_addr_i  (iport_addr),
        .iport_dat_w_i (iport_dat_w),
        .iport_sel_i   (iport_sel),
        .iport_we_i    (iport_we),
        .iport_cyc_i   (iport_cyc),
        .iport_stb_i   (iport_stb),
        .iport_dat_r_o (iport_dat_r),
        .iport_ack_o   (iport_ack),
        .iport_err_o   (iport_err),
        .dport_addr_i  (dport_addr),
        .dport_dat_w_i (dport_dat_w),
        .dport_sel_i   (dport_sel),
        .dport_we_i    (dport_we),
        .dport_cyc_i   (dport_cyc),
        .dport_stb_i   (dport_stb),
        .dport_dat_r_o (dport_dat_r),
        .dport_ack_o   (dport_ack),
        .dport_err_o   (dport_err),
        .bus_addr_o    (bus_addr),
        .bus_dat_w_o   (bus_dat_w),
        .bus_sel_o     (bus_sel),
        .bus_we_o      (bus_we),
        .bus_cyc_o     (bus_cyc),
        .bus_stb_o     (bus_stb),
        .bus_dat_r_i   (bus_dat_r),
        .bus_ack_i     (bus_ack),
        .bus_err_i     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 time unit later, well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rstn = 1'b0;
        iport_addr = '0; iport_dat_w = '0; iport_sel = '0; iport_we = 1'b0;
        iport_cyc = 1'b0; iport_stb = 1'b0;
        dport_addr = '0; dport_dat_w = '0; dport_sel = '0; dport_we = 1'b0;
        dport_cyc = 1'b0; dport_stb = 1'b0;
        bus_dat_r = '0; bus_ack = 1'b0; bus_err = 1'b0;

        // ---- reset state: slave ack must not leak while in reset ----
        tick();
        bus_ack = 1'b1;
        settle();
        check("rst_bus_cyc",  {31'b0, bus_cyc}, 32'd0);
        check("rst_bus_stb",  {31'b0, bus_stb}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_acks",     {30'b0, iport_ack, dport_ack}, 32'd0);
        tick();
        bus_ack = 1'b0;
        rstn = 1'b1;

        // ---- single iport read at 0x100, slave acks one cycle after cyc ----
        iport_addr = 32'h100; iport_sel = 4'hF; iport_we = 1'b0;
        iport_cyc = 1'b1; iport_stb = 1'b1;
        settle();
        check("t2_idle_cyc",  {31'b0, bus_cyc}, 32'd0);
        check("t2_idle_addr", bus_addr, 32'h0);
        tick(); settle();
        check("t2_gnt_cyc",  {31'b0, bus_cyc}, 32'd1);
        check("t2_gnt_addr", bus_addr, 32'h100);
        check("t2_gnt_sel",  {28'b0, bus_sel}, 32'hF);
        check("t2_wait_ack", {31'b0, iport_ack}, 32'd0);
        tick();
        bus_ack = 1'b1; bus_dat_r = 32'hCAFE_0100;
        settle();
        check("t2_iack",   {31'b0, iport_ack}, 32'd1);
        check("t2_idat",   iport_dat_r, 32'hCAFE_0100);
        check("t2_dack",   {31'b0, dport_ack}, 32'd0);
        check("t2_ddat_bc", dport_dat_r, 32'hCAFE_0100);
        tick();
        iport_cyc = 1'b0; iport_stb = 1'b0; bus_ack = 1'b0;
        settle();
        check("t2_after_idle", {31'b0, bus_cyc}, 32'd0);

        // ---- both request in IDLE: dport first, then iport ----
        iport_addr = 32'h200; iport_cyc = 1'b1; iport_stb = 1'b1;
        dport_addr = 32'h300; dport_dat_w = 32'h1234; dport_sel = 4'h3;
        dport_we = 1'b1; dport_cyc = 1'b1; dport_stb = 1'b1;
        settle();
        check("t3_idle_cyc", {31'b0, bus_cyc}, 32'd0);
        tick(); settle();
        check("t3_d_addr", bus_addr, 32'h300);
        check("t3_d_we",   {31'b0, bus_we}, 32'd1);
        check("t3_d_datw", bus_dat_w, 32'h1234);
        check("t3_d_sel",  {28'b0, bus_sel}, 32'h3);
        bus_ack = 1'b1;
        settle();
        check("t3_acks_d", {30'b0, iport_ack, dport_ack}, 32'b01);
        tick();
        dport_cyc = 1'b0; dport_stb = 1'b0; bus_ack = 1'b0;
        settle();
        check("t3_gap_cyc", {31'b0, bus_cyc}, 32'd0);
        tick(); settle();
        check("t3_i_addr", bus_addr, 32'h200);
        check("t3_i_cyc",  {31'b0, bus_cyc}, 32'd1);
        bus_ack = 1'b1;
        settle();
        check("t3_acks_i", {30'b0, iport_ack, dport_ack}, 32'b10);
        tick();
        bus_ack = 1'b0;

        // ---- burst limit: D,D,D,D,I,D with both masters requesting ----
        dport_we = 1'b0; dport_cyc = 1'b1; dport_stb = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            check($sformatf("t4_idle_cyc_%0d", k), {31'b0, bus_cyc}, 32'd0);
            tick(); settle();
            check($sformatf("t4_addr_%0d", k), bus_addr, (k == 4) ? 32'h200 : 32'h300);
            bus_ack = 1'b1;
            settle();
            check($sformatf("t4_acks_%0d", k), {30'b0, iport_ack, dport_ack},
                  (k == 4) ? 32'b10 : 32'b01);
            tick();
            bus_ack = 1'b0;
        end

        // ---- slave error on dport store ----
        iport_cyc = 1'b0; iport_stb = 1'b0;
        dport_addr = 32'h400; dport_dat_w = 32'hDEAD; dport_we = 1'b1;
        settle();
        tick(); settle();
        check("t5_addr", bus_addr, 32'h400);
        check("t5_we",   {31'b0, bus_we}, 32'd1);
        bus_err = 1'b1;
        settle();
        check("t5_derr", {31'b0, dport_err}, 32'd1);
        check("t5_dack", {31'b0, dport_ack}, 32'd0);
        check("t5_ierr", {31'b0, iport_err}, 32'd0);
        tick();
        bus_err = 1'b0; dport_cyc = 1'b0; dport_stb = 1'b0;
        settle();
        check("t5_idle_cyc", {31'b0, bus_cyc}, 32'd0);

        // ---- iport abort before ack, late ack, pending dport next ----
        iport_addr = 32'h500; iport_cyc = 1'b1; iport_stb = 1'b1;
        settle();
        tick(); settle();
        check("t6_gnt_addr", bus_addr, 32'h500);
        check("t6_gnt_cyc",  {31'b0, bus_cyc}, 32'd1);
        tick(); settle();
        check("t6_wait_cyc", {31'b0, bus_cyc}, 32'd1);
        iport_cyc = 1'b0; iport_stb = 1'b0; bus_ack = 1'b1;
        dport_addr = 32'h600; dport_we = 1'b0; dport_cyc = 1'b1; dport_stb = 1'b1;
        settle();
        check("t6_abort_cyc", {31'b0, bus_cyc}, 32'd0);
        check("t6_abort_stb", {31'b0, bus_stb}, 32'd0);
        check("t6_abort_ack", {30'b0, iport_ack, dport_ack}, 32'd0);
        tick(); settle();
        check("t6_late_ack", {30'b0, iport_ack, dport_ack}, 32'd0);
        check("t6_idle_cyc", {31'b0, bus_cyc}, 32'd0);
        bus_ack = 1'b0;
        tick(); settle();
        check("t6_d_cyc",  {31'b0, bus_cyc}, 32'd1);
        check("t6_d_addr", bus_addr, 32'h600);

        // ---- async reset in the middle of a dport grant ----
        rstn = 1'b0; bus_ack = 1'b1;
        settle();
        check("t1_rst_cyc",  {31'b0, bus_cyc}, 32'd0);
        check("t1_rst_dack", {31'b0, dport_ack}, 32'd0);
        check("t1_rst_addr", bus_addr, 32'h0);
        tick(); settle();
        check("t1_rst_hold_cyc", {31'b0, bus_cyc}, 32'd0);
        bus_ack = 1'b0;
        rstn = 1'b1;
        settle();
        check("t1_post_idle", {31'b0, bus_cyc}, 32'd0);
        tick(); settle();
        check("t1_post_gnt", {31'b0, bus_cyc}, 32'd1);
        check("t1_post_addr", bus_addr, 32'h600);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
